exu_dp_core: RTL and testbench

- Execution datapath that terminates the exu_dp_if bus driven by the EXU datapath mux.
- Contains the 32-entry GPR file (x0 hardwired to zero), two combinational read ports, one synchronous write port and the integer ALU.
- Returns gpr_rdata1/gpr_rdata2 and alu_dst to whichever execution unit the mux has selected.
- Also keeps a retired-write counter and a last-write record for the debug/trace port.

---
 rtl/exu_dp_core_if.sv | 31 +++
 rtl/exu_dp_core.sv | 119 +++++++++++
 tb/tb_exu_dp_core.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_dp_core_if.sv
// Bundle between the EXU datapath mux (master) and the execution datapath core (slave).
// Carries the GPR read/write ports and the ALU operand/result lines.
interface exu_dp_if #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned GPR_AW       = 5,
   parameter int unsigned ALU_OPC_SIZE = 4
);
   logic [GPR_AW-1:0]       gpr_raddr1;
   logic [GPR_AW-1:0]       gpr_raddr2;
   logic [XLEN-1:0]         gpr_rdata1;
   logic [XLEN-1:0]         gpr_rdata2;
   logic [GPR_AW-1:0]       gpr_waddr;
   logic [XLEN-1:0]         gpr_wdata;
   logic                    gpr_wen;
   logic [ALU_OPC_SIZE-1:0] alu_opcode;
   logic [XLEN-1:0]         alu_src1;
   logic [XLEN-1:0]         alu_src2;
   logic [XLEN-1:0]         alu_dst;

   modport master (
      output gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
             alu_opcode, alu_src1, alu_src2,
      input  gpr_rdata1, gpr_rdata2, alu_dst
   );

   modport slave (
      input  gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
             alu_opcode, alu_src1, alu_src2,
      output gpr_rdata1, gpr_rdata2, alu_dst
   );
endinterface

// File: rtl/exu_dp_core.sv
// Execution datapath: 32-entry GPR file with x0 hardwired to zero, integer ALU,
// and a retired-write counter plus last-write record for the trace port.
module exu_dp_core #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned GPR_AW    = 5,
   parameter bit          BYPASS_EN = 1'b1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   exu_dp_if.slave           dp_op,
   output logic [CNT_W-1:0]  dbg_wr_cnt,
   output logic [GPR_AW-1:0] dbg_last_waddr,
   output logic [XLEN-1:0]   dbg_last_wdata,
   output logic              dbg_wr_vld
);

   localparam int unsigned NREG = 2 ** GPR_AW;
   localparam int unsigned SHW  = $clog2(XLEN);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   logic [XLEN-1:0]   gpr_q [NREG];
   logic              wr_commit;
   logic [GPR_AW-1:0] raddr [2];
   logic [XLEN-1:0]   rdata [2];

   assign wr_commit = dp_op.gpr_wen && (dp_op.gpr_waddr != '0);

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   // NOTE: the GPRs must all clear on reset, so they are built from flops rather
   // than a RAM macro; a RAM array cannot be reset in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      end else if (wr_commit) begin
         // NOTE: state is always updated with <= so every flop samples pre-edge values.
         gpr_q[dp_op.gpr_waddr] <= dp_op.gpr_wdata;
      end
   end

   assign raddr[0] = dp_op.gpr_raddr1;
   assign raddr[1] = dp_op.gpr_raddr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = gpr_q[raddr[p]];
         if (BYPASS_EN && wr_commit && (raddr[p] == dp_op.gpr_waddr))
            rdata[p] = dp_op.gpr_wdata;
         // x0 wins over everything, including a bypassed write.
         if (raddr[p] == '0)
            rdata[p] = '0;
      end
   end

   assign dp_op.gpr_rdata1 = rdata[0];
   assign dp_op.gpr_rdata2 = rdata[1];

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   logic [XLEN-1:0] src1, src2;
   logic [SHW-1:0]  shamt;

   assign src1  = dp_op.alu_src1;
   assign src2  = dp_op.alu_src2;
   assign shamt = src2[SHW-1:0];

   always_comb begin
      // NOTE: default first so every path assigns alu_dst and no latch is inferred.
      dp_op.alu_dst = '0;
      case (alu_op_e'(dp_op.alu_opcode))
         ALU_ADD:  dp_op.alu_dst = src1 + src2;
         ALU_SUB:  dp_op.alu_dst = src1 - src2;
         ALU_SLL:  dp_op.alu_dst = src1 << shamt;
         ALU_SLT:  dp_op.alu_dst = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
         ALU_SLTU: dp_op.alu_dst = {{(XLEN-1){1'b0}}, (src1 < src2)};
         ALU_XOR:  dp_op.alu_dst = src1 ^ src2;
         ALU_SRL:  dp_op.alu_dst = src1 >> shamt;
         ALU_SRA:  dp_op.alu_dst = $unsigned($signed(src1) >>> shamt);
         ALU_OR:   dp_op.alu_dst = src1 | src2;
         ALU_AND:  dp_op.alu_dst = src1 & src2;
         default:  dp_op.alu_dst = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Debug / trace record
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_wr_cnt     <= '0;
         dbg_last_waddr <= '0;
         dbg_last_wdata <= '0;
         dbg_wr_vld     <= 1'b0;
      end else begin
         dbg_wr_vld <= wr_commit;
         if (wr_commit) begin
            dbg_wr_cnt     <= dbg_wr_cnt + CNT_W'(1);
            dbg_last_waddr <= dp_op.gpr_waddr;
            dbg_last_wdata <= dp_op.gpr_wdata;
         end
      end
   end

endmodule

// File: tb/tb_exu_dp_core.sv
// Self-checking bench for exu_dp_core: bypass, no-bypass and 4-bit-counter instances
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_exu_dp_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  raddr1, raddr2, waddr;
   logic [31:0] wdata, src1, src2;
   logic        wen;
   logic [3:0]  opc;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   exu_dp_if b_if ();
   exu_dp_if n_if ();
   exu_dp_if c_if ();

   assign b_if.gpr_raddr1 = raddr1; assign n_if.gpr_raddr1 = raddr1; assign c_if.gpr_raddr1 = raddr1;
   assign b_if.gpr_raddr2 = raddr2; assign n_if.gpr_raddr2 = raddr2; assign c_if.gpr_raddr2 = raddr2;
   assign b_if.gpr_waddr  = waddr;  assign n_if.gpr_waddr  = waddr;  assign c_if.gpr_waddr  = waddr;
   assign b_if.gpr_wdata  = wdata;  assign n_if.gpr_wdata  = wdata;  assign c_if.gpr_wdata  = wdata;
   assign b_if.gpr_wen    = wen;    assign n_if.gpr_wen    = wen;    assign c_if.gpr_wen    = wen;
   assign b_if.alu_opcode = opc;    assign n_if.alu_opcode = opc;    assign c_if.alu_opcode = opc;
   assign b_if.alu_src1   = src1;   assign n_if.alu_src1   = src1;   assign c_if.alu_src1   = src1;
   assign b_if.alu_src2   = src2;   assign n_if.alu_src2   = src2;   assign c_if.alu_src2   = src2;

   logic [31:0] b_cnt, n_cnt;
   logic [3:0]  c_cnt;
   logic [4:0]  b_lwa, n_lwa, c_lwa;
   logic [31:0] b_lwd, n_lwd, c_lwd;
   logic        b_vld, n_vld, c_vld;

   exu_dp_core #(.BYPASS_EN(1'b1)) u_byp (
      .clk(clk), .rst_n(rst_n), .dp_op(b_if), .dbg_wr_cnt(b_cnt),
      .dbg_last_waddr(b_lwa), .dbg_last_wdata(b_lwd), .dbg_wr_vld(b_vld));

   exu_dp_core #(.BYPASS_EN(1'b0)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .dp_op(n_if), .dbg_wr_cnt(n_cnt),
      .dbg_last_waddr(n_lwa), .dbg_last_wdata(n_lwd), .dbg_wr_vld(n_vld));

   exu_dp_core #(.CNT_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .dp_op(c_if), .dbg_wr_cnt(c_cnt),
      .dbg_last_waddr(c_lwa), .dbg_last_wdata(c_lwd), .dbg_wr_vld(c_vld));

   // Reference model state
   logic [31:0] m_reg [32];
   int unsigned m_cnt;
   logic [4:0]  m_lwa;
   logic [31:0] m_lwd;
   logic        m_vld;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_cnt = 0; m_lwa = '0; m_lwd = '0; m_vld = 1'b0;
   endtask

   // Advance one clock edge, apply the architectural write rules, land 1ns after the edge.
   task automatic cycle();
      @(posedge clk);
      if (rst_n) begin
         m_vld = wen && (waddr != 5'd0);
         if (m_vld) begin
            m_reg[waddr] = wdata;
            m_cnt++;
            m_lwa = waddr;
            m_lwd = wdata;
         end
      end
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && wen && waddr == a) return wdata;
      return m_reg[a];
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] pw;
      pw = 32'd2 ** b[4:0];
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a * pw;
         4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd4: return (a < b) ? 32'd1 : 32'd0;
         4'd5: return a ^ b;
         4'd6: return a / pw;
         4'd7: return a[31] ? ~((~a) / pw) : a / pw;
         4'd8: return a | b;
         4'd9: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_all();
      check("byp_rdata1",  b_if.gpr_rdata1, exp_rd(raddr1, 1'b1));
      check("byp_rdata2",  b_if.gpr_rdata2, exp_rd(raddr2, 1'b1));
      check("nob_rdata1",  n_if.gpr_rdata1, exp_rd(raddr1, 1'b0));
      check("nob_rdata2",  n_if.gpr_rdata2, exp_rd(raddr2, 1'b0));
      check("alu_dst",     b_if.alu_dst,    ref_alu(opc, src1, src2));
      check("wr_cnt",      b_cnt,           m_cnt);
      check("wr_cnt4",     {28'd0, c_cnt},  m_cnt % 16);
      check("last_waddr",  {27'd0, b_lwa},  {27'd0, m_lwa});
      check("last_wdata",  b_lwd,           m_lwd);
      check("wr_vld",      {31'd0, b_vld},  {31'd0, m_vld});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
   } alu_vec_t;

   alu_vec_t vecs [14];

   initial begin
      vecs[0]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[1]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[3]  = '{4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
      vecs[4]  = '{4'd2,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
      vecs[5]  = '{4'd12, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};
      vecs[6]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[7]  = '{4'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
      vecs[8]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[9]  = '{4'd8,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0};
      vecs[10] = '{4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[11] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[12] = '{4'd10, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
      vecs[13] = '{4'd3,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};

      raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0; wen = 1'b0;
      opc = '0; src1 = '0; src2 = '0;
      do_reset();

      // Reset state: every address on both ports reads zero.
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         #1;
         check($sformatf("rst_rd1_x%0d", a), b_if.gpr_rdata1, 32'd0);
         check($sformatf("rst_rd2_x%0d", 31 - a), b_if.gpr_rdata2, 32'd0);
      end
      check("rst_cnt", b_cnt, 32'd0);
      check("rst_vld", {31'd0, b_vld}, 32'd0);
      cycle();

      // Single write to x5 with a one-cycle debug pulse.
      wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd5;
      #1; check_all();
      cycle();
      wen = 1'b0;
      #1;
      check("x5_rd1", b_if.gpr_rdata1, 32'hDEAD_BEEF);
      check("x5_rd2", n_if.gpr_rdata2, 32'hDEAD_BEEF);
      check("x5_cnt", b_cnt, 32'd1);
      check("x5_lwa", {27'd0, b_lwa}, 32'd5);
      check("x5_vld", {31'd0, b_vld}, 32'd1);
      cycle();
      check("x5_vld_drop", {31'd0, b_vld}, 32'd0);

      // Write to x0 is ignored, even through the bypass path.
      wen = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      check("x0_byp_rd1", b_if.gpr_rdata1, 32'd0);
      check("x0_byp_rd2", b_if.gpr_rdata2, 32'd0);
      cycle();
      wen = 1'b0;
      #1;
      check("x0_rd", b_if.gpr_rdata1, 32'd0);
      check("x0_cnt", b_cnt, 32'd1);
      check("x0_vld", {31'd0, b_vld}, 32'd0);
      check("x0_lwa", {27'd0, b_lwa}, 32'd5);

      // Same-cycle write/read of x7: write-through vs stored value.
      wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; raddr1 = 5'd7; raddr2 = 5'd7;
      #1;
      check("x7_byp_rd1", b_if.gpr_rdata1, 32'hA5A5_A5A5);
      check("x7_byp_rd2", b_if.gpr_rdata2, 32'hA5A5_A5A5);
      check("x7_nob_rd1", n_if.gpr_rdata1, 32'd0);
      check("x7_nob_rd2", n_if.gpr_rdata2, 32'd0);
      cycle();
      wen = 1'b0;
      #1;
      check("x7_nob_next", n_if.gpr_rdata1, 32'hA5A5_A5A5);

      // ALU vector table.
      for (int i = 0; i < 14; i++) begin
         opc = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
         #1;
         check($sformatf("alu_vec%0d", i), b_if.alu_dst, vecs[i].y);
         cycle();
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         wen    = ($urandom_range(0, 2) != 0);
         waddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         wdata  = $urandom;
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         opc    = 4'($urandom_range(0, 15));
         src1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         src2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
         #1; check_all();
         cycle();
      end
      wen = 1'b0;
      #1; check_all();

      // Counter wrap on the 4-bit instance: 17 writes -> 1.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wen = 1'b1; waddr = 5'(i + 1); wdata = $urandom;
         cycle();
      end
      wen = 1'b0; raddr1 = 5'd17; raddr2 = 5'd1;
      #1;
      check("wrap_cnt4", {28'd0, c_cnt}, 32'd1);
      check("wrap_cnt32", b_cnt, 32'd17);
      check_all();

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 4; i++) begin
         wen = 1'b1; waddr = 5'(i + 1); wdata = $urandom;
         cycle();
      end
      waddr = 5'd3; wdata = 32'hCAFE_F00D;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_cnt",  b_cnt, 32'd0);
      check("arst_cnt4", {28'd0, c_cnt}, 32'd0);
      check("arst_lwa",  {27'd0, b_lwa}, 32'd0);
      check("arst_lwd",  b_lwd, 32'd0);
      check("arst_vld",  {31'd0, b_vld}, 32'd0);
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a);
         #1;
         check($sformatf("arst_rd_x%0d", a), n_if.gpr_rdata1, 32'd0);
      end
      cycle();
      wen = 1'b0; rst_n = 1'b1; raddr1 = 5'd3; raddr2 = 5'd1;
      #1; check_all();
      cycle();
      check_all();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
